// File: rtl/seg7_display_ctrl_if.sv
// Display-word inputs and segment/scan outputs of the N-digit hex display controller.
// The master side drives the word and display modes; the slave side is the controller.
interface seg7_display_ctrl_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    i_Load;
    logic [4*NUM_DIGITS-1:0] i_Value;
    logic                    i_Blank_Lz;
    logic                    i_Blink;
    logic [7*NUM_DIGITS-1:0] o_Segments;
    logic [6:0]              o_Scan_Seg;
    logic [NUM_DIGITS-1:0]   o_Scan_Sel;

    modport master (
        output i_Load, i_Value, i_Blank_Lz, i_Blink,
        input  o_Segments, o_Scan_Seg, o_Scan_Sel
    );

    modport slave (
        input  i_Load, i_Value, i_Blank_Lz, i_Blink,
        output o_Segments, o_Scan_Seg, o_Scan_Sel
    );
endinterface

// File: rtl/seg7_display_ctrl.sv
// N-digit hex display controller: a latched display word drives per-digit static patterns
// and a time-multiplexed scan bus with a guard slot, leading-zero blanking and blink.

// Per-digit hex glyph decode. The output is active-high (bit0=A .. bit6=G) and reads zero when blanked.
module seg7_digit_dec (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] glyph
);
    always_comb begin
        glyph = 7'h00;
        if (!blank) begin
            case (nib)
                4'h0: glyph = 7'h3F;
                4'h1: glyph = 7'h06;
                4'h2: glyph = 7'h5B;
                4'h3: glyph = 7'h4F;
                4'h4: glyph = 7'h66;
                4'h5: glyph = 7'h6D;
                4'h6: glyph = 7'h7D;
                4'h7: glyph = 7'h07;
                4'h8: glyph = 7'h7F;
                4'h9: glyph = 7'h6F;
                4'hA: glyph = 7'h77;
                4'hB: glyph = 7'h7C;
                4'hC: glyph = 7'h39;
                4'hD: glyph = 7'h5E;
                4'hE: glyph = 7'h79;
                4'hF: glyph = 7'h71;
            endcase
        end
    end
endmodule

module seg7_display_ctrl #(
    parameter int NUM_DIGITS     = 2,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_DIV      = 12500000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic                i_Clk,
    input logic                i_Rst_n,
    seg7_display_ctrl_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // XOR masks that turn active-high internal patterns into pin polarity.
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = DIG_ACTIVE_LOW ? '1 : '0;

    logic [NUM_DIGITS-1:0][3:0] disp_q;
    logic [PW-1:0]              psc_q;
    logic [IW-1:0]              idx_q;
    logic [BW-1:0]              blink_cnt_q;
    logic                       blink_ph_q;
    logic                       psc_wrap;
    logic                       blink_off;
    logic                       zero_run;
    logic [NUM_DIGITS-1:0]      lz_blank;
    logic [NUM_DIGITS-1:0][6:0] glyph;
    logic [NUM_DIGITS-1:0][6:0] seg_q;
    logic [6:0]                 scan_seg_nxt;
    logic [6:0]                 scan_seg_q;
    logic [NUM_DIGITS-1:0]      scan_sel_nxt;
    logic [NUM_DIGITS-1:0]      scan_sel_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            disp_q <= '0;
        else if (bus.i_Load)
            disp_q <= bus.i_Value;
    end

    // Blink phase flips every BLINK_DIV cycles whether or not blink is enabled.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    assign psc_wrap  = (psc_q == PW'(SCAN_DIV - 1));
    assign blink_off = bus.i_Blink & blink_ph_q;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            psc_q <= '0;
            idx_q <= '0;
        end else if (psc_wrap) begin
            psc_q <= '0;
            idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            psc_q <= psc_q + PW'(1);
        end
    end

    // Leading zeros: walk down from the top digit while every digit so far is zero.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run    = zero_run & (disp_q[k] == 4'h0);
            lz_blank[k] = bus.i_Blank_Lz & zero_run;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        seg7_digit_dec u_dec (
            .nib   (disp_q[k]),
            .blank (lz_blank[k] | blink_off),
            .glyph (glyph[k])
        );
    end

    // Prescaler value 0 is the ghosting guard: nothing selected, bus dark.
    always_comb begin
        scan_sel_nxt = '0;
        scan_seg_nxt = 7'h00;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (psc_q != '0 && idx_q == IW'(k)) begin
                scan_sel_nxt[k] = 1'b1;
                scan_seg_nxt    = glyph[k];
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            seg_q      <= {NUM_DIGITS{SEG_OFF}};
            scan_seg_q <= SEG_OFF;
            scan_sel_q <= SEL_OFF;
        end else begin
            seg_q      <= glyph ^ {NUM_DIGITS{SEG_OFF}};
            scan_seg_q <= scan_seg_nxt ^ SEG_OFF;
            scan_sel_q <= scan_sel_nxt ^ SEL_OFF;
        end
    end

    assign bus.o_Segments = seg_q;
    assign bus.o_Scan_Seg = scan_seg_q;
    assign bus.o_Scan_Sel = scan_sel_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: four configurations sharing one clock,
// expected patterns queued when stimulus is driven and compared as outputs appear.
module tb_seg7_display_ctrl;
    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    logic rst_d = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg;
    } scan_t;

    logic [27:0] st_q [$];
    scan_t       sc_q [$];

    seg7_display_ctrl_if #(.NUM_DIGITS(2)) ifa ();
    seg7_display_ctrl_if #(.NUM_DIGITS(4)) ifb ();
    seg7_display_ctrl_if #(.NUM_DIGITS(2)) ifc ();
    seg7_display_ctrl_if #(.NUM_DIGITS(1)) ifd ();

    seg7_display_ctrl dut_a (.i_Clk(clk), .i_Rst_n(rst_a), .bus(ifa));

    seg7_display_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(3),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_b (.i_Clk(clk), .i_Rst_n(rst_b), .bus(ifb));

    seg7_display_ctrl #(
        .NUM_DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(1000),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_c (.i_Clk(clk), .i_Rst_n(rst_c), .bus(ifc));

    seg7_display_ctrl #(
        .NUM_DIGITS(1), .SCAN_DIV(3), .BLINK_DIV(1000)
    ) dut_d (.i_Clk(clk), .i_Rst_n(rst_d), .bus(ifd));

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [27:0] glyphs4(input logic [15:0] v);
        logic [27:0] r;
        r = '0;
        for (int d = 0; d < 4; d++) r[7*d +: 7] = glyph(v[4*d +: 4]);
        return r;
    endfunction

    task automatic test_reset;
        ifa.i_Load = 0; ifa.i_Value = '0; ifa.i_Blank_Lz = 0; ifa.i_Blink = 0;
        ifb.i_Load = 0; ifb.i_Value = '0; ifb.i_Blank_Lz = 0; ifb.i_Blink = 0;
        ifc.i_Load = 0; ifc.i_Value = '0; ifc.i_Blank_Lz = 0; ifc.i_Blink = 0;
        ifd.i_Load = 0; ifd.i_Value = '0; ifd.i_Blank_Lz = 0; ifd.i_Blink = 0;
        rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
        repeat (3) @(negedge clk);
        n_chk++; if (ifa.o_Segments !== 14'h3FFF) $display("FAIL reset_seg_a got %h want 3fff", ifa.o_Segments); else n_pass++;
        n_chk++; if (ifa.o_Scan_Seg !== 7'h7F) $display("FAIL reset_scanseg_a got %h want 7f", ifa.o_Scan_Seg); else n_pass++;
        n_chk++; if (ifa.o_Scan_Sel !== 2'b11) $display("FAIL reset_scansel_a got %b want 11", ifa.o_Scan_Sel); else n_pass++;
        n_chk++; if (ifb.o_Segments !== 28'h0) $display("FAIL reset_seg_b got %h want 0", ifb.o_Segments); else n_pass++;
        n_chk++; if (ifb.o_Scan_Sel !== 4'h0) $display("FAIL reset_scansel_b got %b want 0000", ifb.o_Scan_Sel); else n_pass++;
        n_chk++; if (ifd.o_Scan_Sel !== 1'b1) $display("FAIL reset_scansel_d got %b want 1", ifd.o_Scan_Sel); else n_pass++;
        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
    endtask

    task automatic test_static_load;
        logic [27:0] exp;
        @(negedge clk);
        ifa.i_Value = 8'h3A; ifa.i_Load = 1;
        st_q.push_back({14'h0, 7'h30, 7'h08});
        @(negedge clk);
        ifa.i_Load = 0; ifa.i_Value = 8'hFF;
        // One edge after the load the static set still shows the cleared word (glyph 0, inverted).
        n_chk++; if (ifa.o_Segments !== {7'h40, 7'h40}) $display("FAIL load_latency got %h want 2040", ifa.o_Segments); else n_pass++;
        @(negedge clk);
        exp = st_q.pop_front();
        n_chk++; if (ifa.o_Segments !== exp[13:0]) $display("FAIL load_3a got %h want %h", ifa.o_Segments, exp[13:0]); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (ifa.o_Segments !== exp[13:0]) $display("FAIL load_hold got %h want %h", ifa.o_Segments, exp[13:0]); else n_pass++;
    endtask

    task automatic test_glyphs;
        logic [15:0] words [4];
        logic [27:0] exp;
        words = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifb.i_Value = words[i]; ifb.i_Load = 1;
            st_q.push_back(glyphs4(words[i]));
            @(negedge clk);
            ifb.i_Load = 0;
            @(negedge clk);
            exp = st_q.pop_front();
            n_chk++; if (ifb.o_Segments !== exp) $display("FAIL glyphs_%0d got %h want %h", i, ifb.o_Segments, exp); else n_pass++;
        end
    endtask

    task automatic test_blanking;
        logic [15:0] vals [4];
        logic [27:0] exps [4];
        logic [27:0] exp;
        vals = '{16'h0005, 16'h0A05, 16'h1000, 16'h0000};
        exps = '{{7'h00, 7'h00, 7'h00, 7'h6D}, {7'h00, 7'h77, 7'h3F, 7'h6D},
                 {7'h06, 7'h3F, 7'h3F, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifb.i_Blank_Lz = 1; ifb.i_Value = vals[i]; ifb.i_Load = 1;
            st_q.push_back(exps[i]);
            @(negedge clk);
            ifb.i_Load = 0;
            @(negedge clk);
            exp = st_q.pop_front();
            n_chk++; if (ifb.o_Segments !== exp) $display("FAIL blank_%h got %h want %h", vals[i], ifb.o_Segments, exp); else n_pass++;
        end
        ifb.i_Blank_Lz = 0;
        st_q.push_back({7'h3F, 7'h3F, 7'h3F, 7'h3F});
        @(negedge clk);
        exp = st_q.pop_front();
        n_chk++; if (ifb.o_Segments !== exp) $display("FAIL blank_live_off got %h want %h", ifb.o_Segments, exp); else n_pass++;
        ifb.i_Blank_Lz = 1;
        st_q.push_back({7'h00, 7'h00, 7'h00, 7'h3F});
        @(negedge clk);
        exp = st_q.pop_front();
        n_chk++; if (ifb.o_Segments !== exp) $display("FAIL blank_live_on got %h want %h", ifb.o_Segments, exp); else n_pass++;
        ifb.i_Blank_Lz = 0;
    endtask

    task automatic test_blink;
        logic [27:0] exp;
        scan_t       es;
        logic [15:0] v;
        bit          lit;
        int          c, pos, dig;
        @(negedge clk);
        rst_b = 0; ifb.i_Blink = 1; ifb.i_Load = 0;
        @(negedge clk);
        rst_b = 1; ifb.i_Value = 16'h1234; ifb.i_Load = 1;
        for (int e = 1; e <= 13; e++) begin
            v   = (e == 1) ? 16'h0000 : 16'h1234;
            lit = (((e - 1) / 3) % 2) == 0;
            c   = e - 1; pos = c % 4; dig = (c / 4) % 4;
            st_q.push_back(lit ? glyphs4(v) : 28'h0);
            es.sel = (pos == 0) ? 4'h0 : 4'(1 << dig);
            es.seg = (pos != 0 && lit) ? glyph(v[4*dig +: 4]) : 7'h00;
            sc_q.push_back(es);
        end
        for (int e = 1; e <= 13; e++) begin
            @(negedge clk);
            ifb.i_Load = 0;
            exp = st_q.pop_front();
            es  = sc_q.pop_front();
            n_chk++; if (ifb.o_Segments !== exp) $display("FAIL blink_static_e%0d got %h want %h", e, ifb.o_Segments, exp); else n_pass++;
            n_chk++; if ({ifb.o_Scan_Sel, ifb.o_Scan_Seg} !== {es.sel, es.seg})
                $display("FAIL blink_scan_e%0d got %b/%h want %b/%h", e, ifb.o_Scan_Sel, ifb.o_Scan_Seg, es.sel, es.seg);
            else n_pass++;
        end
        ifb.i_Blink = 0;
        for (int i = 0; i < 6; i++) st_q.push_back(glyphs4(16'h1234));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = st_q.pop_front();
            n_chk++; if (ifb.o_Segments !== exp) $display("FAIL blink_off_%0d got %h want %h", i, ifb.o_Segments, exp); else n_pass++;
        end
    endtask

    task automatic test_scan;
        scan_t es;
        int    pos, dig;
        @(negedge clk);
        rst_c = 0; ifc.i_Load = 0;
        @(negedge clk);
        rst_c = 1; ifc.i_Value = 8'h3A; ifc.i_Load = 1;
        for (int c = 0; c < 16; c++) begin
            pos = c % 4; dig = (c / 4) % 2;
            es.sel = (pos == 0) ? 4'h0 : 4'(1 << dig);
            es.seg = (pos == 0) ? 7'h00 : glyph(dig == 1 ? 4'h3 : 4'hA);
            sc_q.push_back(es);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ifc.i_Load = 0;
            es = sc_q.pop_front();
            n_chk++; if ({2'b00, ifc.o_Scan_Sel, ifc.o_Scan_Seg} !== {es.sel, es.seg})
                $display("FAIL scan_c%0d got %b/%h want %b/%h", c, ifc.o_Scan_Sel, ifc.o_Scan_Seg, es.sel, es.seg);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        bit found;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifc.o_Scan_Sel === 2'b10) found = 1;
        end
        n_chk++; if (!found) $display("FAIL arst_wait_digit1 got sel %b want 10 within 20 cycles", ifc.o_Scan_Sel); else n_pass++;
        #2 rst_c = 0;
        #1;
        n_chk++; if (ifc.o_Scan_Sel !== 2'b00) $display("FAIL arst_sel got %b want 00", ifc.o_Scan_Sel); else n_pass++;
        n_chk++; if (ifc.o_Scan_Seg !== 7'h00) $display("FAIL arst_seg got %h want 00", ifc.o_Scan_Seg); else n_pass++;
        n_chk++; if (ifc.o_Segments !== 14'h0) $display("FAIL arst_static got %h want 0", ifc.o_Segments); else n_pass++;
        @(negedge clk);
        rst_c = 1;
        @(negedge clk);
        n_chk++; if (ifc.o_Scan_Sel !== 2'b00) $display("FAIL arst_edge1_sel got %b want 00", ifc.o_Scan_Sel); else n_pass++;
        @(negedge clk);
        n_chk++; if ({ifc.o_Scan_Sel, ifc.o_Scan_Seg} !== {2'b01, 7'h3F})
            $display("FAIL arst_edge2 got %b/%h want 01/3f", ifc.o_Scan_Sel, ifc.o_Scan_Seg);
        else n_pass++;
    endtask

    task automatic test_load_slot_change;
        scan_t       es;
        logic [7:0]  v;
        int          pos, dig;
        @(negedge clk);
        rst_c = 0;
        @(negedge clk);
        rst_c = 1; ifc.i_Value = 8'h3A; ifc.i_Load = 1;
        for (int c = 0; c < 12; c++) begin
            v = (c < 4) ? 8'h3A : 8'h5C;
            pos = c % 4; dig = (c / 4) % 2;
            es.sel = (pos == 0) ? 4'h0 : 4'(1 << dig);
            es.seg = (pos == 0) ? 7'h00 : glyph(v[4*dig +: 4]);
            sc_q.push_back(es);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            es = sc_q.pop_front();
            n_chk++; if ({2'b00, ifc.o_Scan_Sel, ifc.o_Scan_Seg} !== {es.sel, es.seg})
                $display("FAIL slotload_c%0d got %b/%h want %b/%h", c, ifc.o_Scan_Sel, ifc.o_Scan_Seg, es.sel, es.seg);
            else n_pass++;
            // The new word is latched on the prescaler-wrap edge (4th edge after release).
            if (c == 0) ifc.i_Load = 0;
            if (c == 2) begin ifc.i_Value = 8'h5C; ifc.i_Load = 1; end
            if (c == 3) ifc.i_Load = 0;
        end
    endtask

    task automatic test_single_digit;
        scan_t es;
        int    pos;
        @(negedge clk);
        rst_d = 0;
        @(negedge clk);
        rst_d = 1; ifd.i_Value = 4'h2; ifd.i_Load = 1;
        for (int c = 0; c < 9; c++) begin
            pos = c % 3;
            es.sel = (pos == 0) ? 4'h1 : 4'h0;
            es.seg = (pos == 0) ? 7'h7F : ~glyph(4'h2);
            sc_q.push_back(es);
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            ifd.i_Load = 0;
            es = sc_q.pop_front();
            n_chk++; if ({3'b000, ifd.o_Scan_Sel, ifd.o_Scan_Seg} !== {es.sel, es.seg})
                $display("FAIL single_c%0d got %b/%h want %b/%h", c, ifd.o_Scan_Sel, ifd.o_Scan_Seg, es.sel, es.seg);
            else n_pass++;
        end
        n_chk++; if (ifd.o_Segments !== 7'h24) $display("FAIL single_static got %h want 24", ifd.o_Segments); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_static_load();
        test_glyphs();
        test_blanking();
        test_blink();
        test_scan();
        test_async_reset();
        test_load_slot_change();
        test_single_digit();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
